// File: rtl/spi_rsp_pkg.sv
// Shared types and constants for the spi_slave_rsp SPI mode-0 responder.
package spi_rsp_pkg;

  localparam int unsigned BITS_PER_FRAME = 8;
  localparam int unsigned MIN_SCK_DIV    = 8;
  localparam int unsigned BitCntW        = $clog2(BITS_PER_FRAME + 1);

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-stage pin synchronizer with registered rise/fall pulses for one SPI pin.
module spi_pin_sync #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;
  logic              sync_out;

  assign sync_out = sync_q[Stages-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {Stages{ResetVal}};
      prev_q <= ResetVal;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], pin_i};
      prev_q <= sync_out;
      rise_q <= sync_out & ~prev_q;
      fall_q <= ~sync_out & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave_rsp.sv
// SPI mode-0 responder: oversampled pins, rx/tx bytes on valid/ready streams.
module spi_slave_rsp
  import spi_rsp_pkg::*;
#(
  parameter logic [7:0]  DUMMY_BYTE  = 8'hFF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_cs,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       rx_overrun,
  output logic       tx_underrun,
  output logic       busy
);

  localparam logic [BitCntW-1:0] LastBit = BitCntW'(BITS_PER_FRAME - 1);
  localparam logic [BitCntW-1:0] FullCnt = BitCntW'(BITS_PER_FRAME);

  logic cs_rise, cs_fall, sck_rise, sck_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   mosi_sync;

  spi_pin_sync #(
    .Stages   (SYNC_STAGES),
    .ResetVal (1'b1)
  ) u_cs_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_i  (spi_cs),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  spi_pin_sync #(
    .Stages   (SYNC_STAGES),
    .ResetVal (1'b0)
  ) u_sck_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_i  (spi_clk),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  // mosi needs no edge detect; its one-cycle lead over the sck pulse is harmless
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_q <= '0;
    else        mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
  end
  assign mosi_sync = mosi_q[SYNC_STAGES-1];

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cs_fall) state_d = StShift;
      StShift: if (cs_rise) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    spi_miso_oe = (state_q == StShift);
    busy        = (state_q == StShift);
  end

  logic [BitCntW-1:0] bitcnt_q, bitcnt_d;
  logic [7:0]         tx_shift_q, tx_shift_d;
  logic [7:0]         rx_shift_q, rx_shift_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               miso_q, miso_d;
  logic               tx_ready_q, tx_ready_d;
  logic               underrun_q, underrun_d;
  logic               overrun_q, overrun_d;
  logic               in_shift, do_load, do_shift, do_sample, do_abort;

  // cs rise wins over a coincident sck edge, so the closing edge never loads
  assign in_shift  = (state_q == StShift);
  assign do_abort  = in_shift & cs_rise;
  assign do_load   = ((state_q == StIdle) & cs_fall)
                   | (in_shift & ~cs_rise & sck_fall & (bitcnt_q == FullCnt));
  assign do_shift  = in_shift & ~cs_rise & sck_fall & (bitcnt_q != '0) & (bitcnt_q != FullCnt);
  assign do_sample = in_shift & ~cs_rise & sck_rise;

  always_comb begin
    bitcnt_d   = bitcnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    miso_d     = miso_q;
    tx_ready_d = 1'b0;
    underrun_d = 1'b0;
    overrun_d  = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (do_load) begin
      tx_shift_d = tx_valid ? tx_data : DUMMY_BYTE;
      tx_ready_d = tx_valid;
      underrun_d = ~tx_valid;
      miso_d     = tx_shift_d[7];
      bitcnt_d   = '0;
    end else if (do_shift) begin
      tx_shift_d = {tx_shift_q[6:0], 1'b0};
      miso_d     = tx_shift_q[6];
    end

    if (do_sample) begin
      rx_shift_d = {rx_shift_q[6:0], mosi_sync};
      bitcnt_d   = bitcnt_q + BitCntW'(1);
      if (bitcnt_q == LastBit) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_d  = {rx_shift_q[6:0], mosi_sync};
          rx_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
    end

    if (do_abort) begin
      bitcnt_d = '0;
      miso_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt_q   <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b1;
      tx_ready_q <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      bitcnt_q   <= bitcnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      miso_q     <= miso_d;
      tx_ready_q <= tx_ready_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

  assign spi_miso    = miso_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = tx_ready_q;
  assign tx_underrun = underrun_q;
  assign rx_overrun  = overrun_q;

endmodule
